// File: rtl/des_key_search.sv
`default_nettype none
// ============================================================================
// Module      : des_key_search
// Description : Brute-force DES key range sweeper driving LANES external DES
//               lanes. Optional macro DES_SEARCH_CONTINUE_EN keeps searching
//               after a hit and adds a saturating match_count output.
// Revision    : 1.0 - initial release
// ============================================================================
module des_key_search #(
    parameter int LANES   = 28,
    parameter int LATENCY = 16,
    parameter int KEY_W   = 56,
    parameter int CT_W    = 64
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    input  logic                   start,
    input  logic                   abort,
    input  logic [KEY_W-1:0]       key_lo,
    input  logic [KEY_W-1:0]       key_hi,
    input  logic [CT_W-1:0]        target_ct,
    output logic [LANES*KEY_W-1:0] lane_key,
    input  logic [LANES*CT_W-1:0]  lane_ct,
    output logic                   busy,
    output logic                   done,
    output logic                   found,
    output logic [KEY_W-1:0]       found_key,
    output logic [KEY_W:0]         keys_tested
`ifdef DES_SEARCH_CONTINUE_EN
    ,
    output logic [7:0]             match_count
`endif
);

    localparam int c_SW = KEY_W + 1;
    localparam int c_IW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int c_PW = $clog2(LANES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_DRAIN,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t           r_state;
    logic [KEY_W-1:0] r_base;
    logic [KEY_W-1:0] r_key_hi;
    logic [5:0]       r_drain_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_found;
    logic [KEY_W-1:0] r_found_key;
    logic [KEY_W:0]   r_keys_tested;

    logic [LANES-1:0] w_issue_mask;
    logic [KEY_W:0]   w_last_sum;
    logic             w_final;
    logic [KEY_W-1:0] w_out_base;
    logic [LANES-1:0] w_out_mask;
    logic [LANES-1:0] w_hit;
    logic             w_any_hit;
    logic [c_IW-1:0]  w_hit_idx;
    logic [c_PW-1:0]  w_tested_inc;
    logic [KEY_W-1:0] w_hit_key;
    logic             w_stop;
    logic             w_flush;

    // Lane keys and validity: a lane is live only inside the range and
    // without carrying out of the KEY_W-bit key space.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [KEY_W:0] w_sum;
            assign w_sum = {1'b0, r_base} + c_SW'(gi);
            assign lane_key[gi*KEY_W +: KEY_W] = w_sum[KEY_W-1:0];
            assign w_issue_mask[gi] = (r_state == S_SEARCH) && !w_sum[KEY_W] &&
                                      (w_sum[KEY_W-1:0] <= r_key_hi);
        end
    endgenerate

    assign w_last_sum = {1'b0, r_base} + c_SW'(LANES - 1);
    assign w_final    = (w_last_sum >= {1'b0, r_key_hi});

    // Tag pipeline matching the external lane latency.
    generate
        if (LATENCY == 0) begin : g_nodelay
            assign w_out_base = r_base;
            assign w_out_mask = w_issue_mask;
        end else begin : g_delay
            logic [KEY_W-1:0] r_dl_base [LATENCY];
            logic [LANES-1:0] r_dl_mask [LATENCY];

            always_ff @(posedge CLOCK_50 or posedge RESET) begin
                if (RESET) begin
                    for (int s = 0; s < LATENCY; s++) begin
                        r_dl_base[s] <= '0;
                        r_dl_mask[s] <= '0;
                    end
                end else begin
                    r_dl_base[0] <= r_base;
                    r_dl_mask[0] <= w_flush ? '0 : w_issue_mask;
                    for (int s = 1; s < LATENCY; s++) begin
                        r_dl_base[s] <= r_dl_base[s-1];
                        r_dl_mask[s] <= w_flush ? '0 : r_dl_mask[s-1];
                    end
                end
            end

            assign w_out_base = r_dl_base[LATENCY-1];
            assign w_out_mask = r_dl_mask[LATENCY-1];
        end
    endgenerate

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_cmp
            assign w_hit[gi] = w_out_mask[gi] && (lane_ct[gi*CT_W +: CT_W] == target_ct);
        end
    endgenerate

    always_comb begin
        w_any_hit    = 1'b0;
        w_hit_idx    = '0;
        w_tested_inc = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_any_hit = 1'b1;
                w_hit_idx = c_IW'(i);
            end
        end
        for (int i = 0; i < LANES; i++) begin
            w_tested_inc = w_tested_inc + c_PW'(w_out_mask[i]);
        end
    end

    assign w_hit_key = w_out_base + KEY_W'(w_hit_idx);

`ifdef DES_SEARCH_CONTINUE_EN
    logic [7:0]      r_match_count;
    logic [c_PW-1:0] w_hit_cnt;
    logic [8:0]      w_mc_sum;

    always_comb begin
        w_hit_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_hit_cnt = w_hit_cnt + c_PW'(w_hit[i]);
        end
    end

    assign w_mc_sum    = 9'(r_match_count) + 9'(w_hit_cnt);
    assign w_stop      = 1'b0;
    assign match_count = r_match_count;
`else
    assign w_stop      = w_any_hit;
`endif

    assign w_flush = abort || w_stop;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_base        <= '0;
            r_key_hi      <= '0;
            r_drain_cnt   <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_found       <= 1'b0;
            r_found_key   <= '0;
            r_keys_tested <= '0;
`ifdef DES_SEARCH_CONTINUE_EN
            r_match_count <= '0;
`endif
        end else if (abort) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_FOUND, S_EXHAUSTED: begin
                    if (start) begin
                        r_keys_tested <= '0;
                        r_found       <= 1'b0;
                        r_found_key   <= '0;
`ifdef DES_SEARCH_CONTINUE_EN
                        r_match_count <= '0;
`endif
                        if (key_lo <= key_hi) begin
                            r_state  <= S_SEARCH;
                            r_base   <= key_lo;
                            r_key_hi <= key_hi;
                            r_busy   <= 1'b1;
                            r_done   <= 1'b0;
                        end else begin
                            r_state <= S_EXHAUSTED;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_SEARCH, S_DRAIN: begin
                    r_keys_tested <= r_keys_tested + c_SW'(w_tested_inc);
`ifdef DES_SEARCH_CONTINUE_EN
                    if (w_any_hit) begin
                        if (!r_found) begin
                            r_found     <= 1'b1;
                            r_found_key <= w_hit_key;
                        end
                        r_match_count <= w_mc_sum[8] ? 8'hFF : w_mc_sum[7:0];
                    end
`endif
                    if (w_stop) begin
                        r_state     <= S_FOUND;
                        r_found     <= 1'b1;
                        r_found_key <= w_hit_key;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                    end else if (r_state == S_SEARCH) begin
                        if (w_final) begin
                            r_drain_cnt <= '0;
                            if (LATENCY == 0) begin
                                r_state <= S_EXHAUSTED;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_DRAIN;
                            end
                        end else begin
                            r_base <= r_base + KEY_W'(LANES);
                        end
                    end else begin
                        // Final issue reaches the comparator on the last drain cycle.
                        if (r_drain_cnt == 6'(LATENCY - 1)) begin
                            r_state <= S_EXHAUSTED;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 6'd1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign found       = r_found;
    assign found_key   = r_found_key;
    assign keys_tested = r_keys_tested;

endmodule
`default_nettype wire
